// File: rtl/countdown_timer.sv
// Countdown timer with load, start/pause control and optional auto-reload.
// Vectors are declared [0:WIDTH-1], so bit 0 is the MSB and arithmetic is
// ordinary unsigned arithmetic on the whole vector.
module countdown_timer #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned INIT  = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [0:WIDTH-1] load_val,
   input  logic             start,
   input  logic             pause,
   input  logic             auto_reload,
   output logic [0:WIDTH-1] count,
   output logic             busy,
   output logic             expire
);

   typedef enum logic [1:0] {StIdle, StRun, StPaused} state_e;

   localparam logic [0:WIDTH-1] InitVal = WIDTH'(INIT);
   localparam logic [0:WIDTH-1] One     = WIDTH'(1);

   state_e           state_q, state_d;
   logic [0:WIDTH-1] count_q, count_d;
   logic [0:WIDTH-1] reload_q, reload_d;
   logic             expire_q, expire_d;

   // Next-state: load beats pause, pause beats start; expire is a one-cycle pulse.
   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      reload_d = reload_q;
      expire_d = 1'b0;
      if (load) begin
         count_d  = load_val;
         reload_d = load_val;
         state_d  = StIdle;
      end else if (pause) begin
         // Pause only matters while running; elsewhere it still masks start.
         if (state_q == StRun) begin
            state_d = StPaused;
         end
      end else begin
         case (state_q)
            StIdle, StPaused: begin
               if (start && (count_q != '0)) begin
                  state_d = StRun;
               end
            end
            StRun: begin
               if (count_q > One) begin
                  count_d = count_q - One;
               end else if (count_q == One) begin
                  expire_d = 1'b1;
                  if (auto_reload && (reload_q != '0)) begin
                     count_d = reload_q;
                  end else begin
                     count_d = '0;
                     state_d = StIdle;
                  end
               end else begin
                  // Running at zero cannot be reached; fall back to idle.
                  state_d = StIdle;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q  <= StIdle;
         count_q  <= InitVal;
         reload_q <= InitVal;
         expire_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         reload_q <= reload_d;
         expire_q <= expire_d;
      end
   end

   assign count  = count_q;
   assign busy   = (state_q == StRun);
   assign expire = expire_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: directed scenarios with literal
// expectations, then random stimulus against a behavioural model. Two
// instances (32-bit INIT 0, 4-bit INIT 9) share the control inputs.
module tb_countdown_timer;

   logic        clk = 1'b0;
   logic        rst, load, start, pause, auto_reload;
   logic [31:0] lv;
   logic [3:0]  lv4;
   logic [31:0] c32;
   logic [3:0]  c4;
   logic        b32, b4, e32, e4;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   assign lv4 = lv[3:0];

   countdown_timer #(.WIDTH(32), .INIT(0)) dut32 (
      .clk(clk), .rst(rst), .load(load), .load_val(lv), .start(start), .pause(pause),
      .auto_reload(auto_reload), .count(c32), .busy(b32), .expire(e32)
   );

   countdown_timer #(.WIDTH(4), .INIT(9)) dut4 (
      .clk(clk), .rst(rst), .load(load), .load_val(lv4), .start(start), .pause(pause),
      .auto_reload(auto_reload), .count(c4), .busy(b4), .expire(e4)
   );

   // Reference model: k=0 is the 32-bit instance, k=1 the 4-bit one.
   longint unsigned m_mask[2] = '{64'hFFFF_FFFF, 64'hF};
   longint unsigned m_init[2] = '{64'd0, 64'd9};
   longint unsigned m_cnt[2];
   longint unsigned m_rel[2];
   bit              m_run[2];
   bit              m_exp[2];

   task automatic chk(input string nm, input longint unsigned act, input longint unsigned req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0d, required %0d (t=%0t)", nm, act, req, $time);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Model update from the behavioural rules, one step per rising edge.
   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         m_exp[k] <= 1'b0;
         if (!rst) begin
            m_cnt[k] <= m_init[k];
            m_rel[k] <= m_init[k];
            m_run[k] <= 1'b0;
         end else if (load) begin
            m_cnt[k] <= 64'(lv) & m_mask[k];
            m_rel[k] <= 64'(lv) & m_mask[k];
            m_run[k] <= 1'b0;
         end else if (pause) begin
            m_run[k] <= 1'b0;
         end else if (m_run[k]) begin
            if (m_cnt[k] > 1) begin
               m_cnt[k] <= m_cnt[k] - 1;
            end else begin
               m_exp[k] <= (m_cnt[k] == 1);
               if (m_cnt[k] == 1 && auto_reload && m_rel[k] != 0) begin
                  m_cnt[k] <= m_rel[k];
               end else begin
                  m_cnt[k] <= 0;
                  m_run[k] <= 1'b0;
               end
            end
         end else if (start && m_cnt[k] != 0) begin
            m_run[k] <= 1'b1;
         end
      end
   end

   // Every-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("model_cnt32", 64'(c32), m_cnt[0]);
         chk("model_busy32", 64'(b32), 64'(m_run[0]));
         chk("model_exp32", 64'(e32), 64'(m_exp[0]));
         chk("model_cnt4", 64'(c4), m_cnt[1]);
         chk("model_busy4", 64'(b4), 64'(m_run[1]));
         chk("model_exp4", 64'(e4), 64'(m_exp[1]));
      end
   end

   initial begin
      int n;
      rst = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0; auto_reload = 1'b0; lv = '0;
      tick(); tick();
      chk_en = 1'b1;
      chk("rst_cnt32", 64'(c32), 64'd0);
      chk("rst_cnt4", 64'(c4), 64'd9);
      chk("rst_busy", 64'(b32), 64'd0);
      chk("rst_exp", 64'(e32), 64'd0);
      rst = 1'b1;

      // One-shot countdown from 5.
      load = 1'b1; lv = 5; tick(); load = 1'b0;
      chk("load5_cnt", 64'(c32), 64'd5);
      start = 1'b1; tick(); start = 1'b0;
      chk("start_cnt", 64'(c32), 64'd5);
      chk("start_busy", 64'(b32), 64'd1);
      for (int v = 4; v >= 1; v--) begin
         tick();
         chk("down_cnt", 64'(c32), 64'(v));
         chk("down_exp", 64'(e32), 64'd0);
      end
      tick();
      chk("zero_cnt", 64'(c32), 64'd0);
      chk("zero_busy", 64'(b32), 64'd0);
      chk("zero_exp", 64'(e32), 64'd1);
      tick();
      chk("post_exp", 64'(e32), 64'd0);

      // Auto-reload with period 3.
      auto_reload = 1'b1;
      load = 1'b1; lv = 3; tick(); load = 1'b0;
      start = 1'b1; tick(); start = 1'b0;
      chk("ar_first", 64'(c32), 64'd3);
      for (int i = 1; i <= 10; i++) begin
         tick();
         chk("ar_cnt", 64'(c32), 64'((i % 3 == 0) ? 3 : 3 - (i % 3)));
         chk("ar_exp", 64'(e32), 64'(i % 3 == 0));
         chk("ar_busy", 64'(b32), 64'd1);
      end
      auto_reload = 1'b0;
      load = 1'b1; lv = 0; tick(); load = 1'b0;

      // Pause at 7: three paused cycles plus the resume cycle stall 4 cycles,
      // so expire lands at cycle 14 after start instead of 10.
      load = 1'b1; lv = 10; tick(); load = 1'b0;
      start = 1'b1; tick(); start = 1'b0;
      chk("p_cnt10", 64'(c32), 64'd10);
      tick(); tick(); tick();
      chk("p_cnt7", 64'(c32), 64'd7);
      pause = 1'b1; tick(); pause = 1'b0;
      chk("p_hold_busy", 64'(b32), 64'd0);
      tick(); tick();
      chk("p_hold_cnt", 64'(c32), 64'd7);
      start = 1'b1; tick(); start = 1'b0;
      chk("p_resume_cnt", 64'(c32), 64'd7);
      chk("p_resume_busy", 64'(b32), 64'd1);
      tick();
      chk("p_cnt6", 64'(c32), 64'd6);
      n = 8;
      while (!e32 && n < 40) begin
         tick();
         n++;
      end
      chk("p_expire_cycle", 64'(n), 64'd14);

      // All three requests together: load wins, stays idle.
      load = 1'b1; pause = 1'b1; start = 1'b1; lv = 8; tick();
      load = 1'b0; pause = 1'b0; start = 1'b0;
      chk("prio_cnt", 64'(c32), 64'd8);
      chk("prio_busy", 64'(b32), 64'd0);
      tick();
      chk("prio_idle", 64'(b32), 64'd0);
      load = 1'b1; lv = 0; tick(); load = 1'b0;
      start = 1'b1; tick(); start = 1'b0;
      chk("zstart_busy", 64'(b32), 64'd0);
      chk("zstart_exp", 64'(e32), 64'd0);

      // Reset in the middle of a run.
      load = 1'b1; lv = 6; tick(); load = 1'b0;
      start = 1'b1; tick(); start = 1'b0;
      tick(); tick();
      chk("r_cnt4", 64'(c32), 64'd4);
      rst = 1'b0; start = 1'b1; tick();
      chk("r_cnt", 64'(c32), 64'd0);
      chk("r_busy", 64'(b32), 64'd0);
      chk("r_exp", 64'(e32), 64'd0);
      tick();
      chk("r_hold_busy", 64'(b32), 64'd0);
      rst = 1'b1; tick(); start = 1'b0;
      chk("r_ign_busy", 64'(b32), 64'd0);
      load = 1'b1; lv = 2; tick(); load = 1'b0;
      start = 1'b1; tick(); start = 1'b0;
      chk("r_restart_busy", 64'(b32), 64'd1);
      tick(); tick(); tick();

      // 4-bit instance, reload 15: period 15, never shows 0 or wraps.
      auto_reload = 1'b1;
      load = 1'b1; lv = 15; tick(); load = 1'b0;
      start = 1'b1; tick(); start = 1'b0;
      chk("w4_first", 64'(c4), 64'd15);
      for (int i = 1; i <= 31; i++) begin
         tick();
         chk("w4_cnt", 64'(c4), 64'((i % 15 == 0) ? 15 : 15 - (i % 15)));
         chk("w4_exp", 64'(e4), 64'(i % 15 == 0));
      end
      auto_reload = 1'b0;
      load = 1'b1; lv = 0; tick(); load = 1'b0;

      // Random phase; pause and start never requested together without load.
      for (int i = 0; i < 3000; i++) begin
         int r;
         rst  = ($urandom_range(0, 199) != 0);
         load = ($urandom_range(0, 19) == 0);
         lv   = ($urandom_range(0, 7) == 0) ? $urandom : $urandom_range(0, 24);
         r    = $urandom_range(0, 9);
         pause = (r == 0);
         start = (r >= 1 && r <= 3);
         if ($urandom_range(0, 29) == 0) auto_reload = ~auto_reload;
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 SHALL have parameter WIDTH, default 32: counter and load-value width in bits.
REQ-002 SHALL have parameter INIT, default 0: count and reload value after reset.
REQ-003 SHALL have port clk  input  1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1: reset, synchronous, active-low; sampled on the rising edge of clk.
REQ-005 SHALL have port load  input  1: when high, capture load_val into count and reload registers.
REQ-006 SHALL have port load_val  input  [0:WIDTH-1]: value for load; bit 0 is MSB.
REQ-007 SHALL have port start  input  1: single-cycle request to begin or resume counting.
REQ-008 SHALL have port pause  input  1: single-cycle request to suspend counting.
REQ-009 SHALL have port auto_reload  input  1: level; selects reload-and-continue on expiry.
REQ-010 SHALL have port count  output  [0:WIDTH-1]: current registered count; bit 0 is MSB.
REQ-011 SHALL have port busy  output  1: high while state is RUN.
REQ-012 SHALL have port expire  output  1: registered one-cycle pulse on terminal count.

Function
REQ-013 SHALL implement states IDLE, RUN and PAUSED; busy = (state == RUN).
REQ-014 SHALL hold count unchanged in IDLE and PAUSED.
REQ-015 SHALL, on load, set count and reload to load_val, enter IDLE and drive expire low next cycle, from any state.
REQ-016 SHALL apply input priority load > pause > start when several are high in one cycle.
REQ-017 SHALL, on start in IDLE or PAUSED with count != 0, enter RUN; the first decrement is visible one cycle after entering RUN.
REQ-018 SHALL ignore start when count == 0, and ignore start while already in RUN.
REQ-019 SHALL, on pause in RUN, enter PAUSED with count frozen at its current value; pause in IDLE or PAUSED has no effect.
REQ-020 SHALL, in RUN with count > 1 and no load/pause, decrement count by 1 per cycle, modulo 2^WIDTH unsigned.
REQ-021 SHALL, in RUN with count == 1 and auto_reload low, set count to 0, enter IDLE and pulse expire high for exactly the next cycle.
REQ-022 SHALL, in RUN with count == 1 and auto_reload high, set count to reload, pulse expire for one cycle and remain in RUN; if reload == 0, enter IDLE instead.
REQ-023 SHALL give a period of exactly reload cycles between consecutive expire pulses in auto-reload mode.
REQ-024 SHALL treat load coinciding with terminal count as load only: no expire pulse.
REQ-025 SHALL treat pause coinciding with count == 1 as pause only: count stays 1 and no expire pulse.
REQ-026 SHALL never underflow count below 0 and never wrap to all-ones.

Reset
REQ-027 SHALL, when rst is low at a clock edge, set count = INIT, reload = INIT, state = IDLE, busy = 0 and expire = 0, overriding all other inputs.
REQ-028 SHALL abort any run or pause in progress on reset, with no expire pulse produced.
REQ-029 SHALL keep all outputs stable at reset values while rst stays low, resuming normal operation on the first edge with rst high.

Verification
REQ-030 Bench SHALL cover: load 5, start, auto_reload=0 -> count 5,4,3,2,1,0 on consecutive cycles; expire high only in the cycle count first reads 0; busy falls with it.
REQ-031 Bench SHALL cover: load 3, auto_reload=1, start, run 10 cycles -> count 3,2,1,3,2,1,3...; expire pulses every 3 cycles; busy stays 1.
REQ-032 Bench SHALL cover: load 10, start, pause at count 7 for 4 cycles, then start -> count holds 7 while paused, then resumes 6,5,...; expire arrives 4 cycles later than unpaused.
REQ-033 Bench SHALL cover: load, pause and start asserted in the same cycle with load_val 8 -> count 8, state IDLE; and start with count 0 -> no busy, no expire.
REQ-034 Bench SHALL cover: rst low mid-run at count 4 with INIT 0 -> next cycle count 0, busy 0, expire 0, then start is ignored until a nonzero load.
REQ-035 Bench SHALL cover: WIDTH=4, load 15, auto_reload=1 -> 15-cycle period, count never wraps to 15 through 0.
